// File: rtl/led_trail_pwm.sv
// Per-channel LED fader: a high input snaps its channel to full brightness, then the level
// decays in steps once the input drops. The level is scaled by a global dim and driven out as 8-bit PWM.
module led_trail_pwm #(
    parameter int N_CH       = 4,
    parameter int DECAY_DIV  = 47000,
    parameter int DECAY_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] led_in,
    input  logic [7:0]      dim,
    output logic [N_CH-1:0] led_out
);

    localparam int              PW         = $clog2(DECAY_DIV);
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(DECAY_DIV - 1);
    localparam logic [7:0]      STEP       = 8'(DECAY_STEP);
    localparam logic [7:0]      LEVEL_FULL = 8'd255;

    logic [7:0]      pwm_cnt_r;
    logic [7:0]      pwm_cnt_nxt_s;
    logic [PW-1:0]   presc_r;
    logic [PW-1:0]   presc_nxt_s;
    logic            tick_s;
    logic [8:0]      dim_p1_s;
    logic [7:0]      level_r     [N_CH];
    logic [7:0]      level_nxt_s [N_CH];
    logic [7:0]      eff_r       [N_CH];
    logic [7:0]      eff_nxt_s   [N_CH];
    logic [N_CH-1:0] led_out_r;
    logic [N_CH-1:0] led_out_nxt_s;

    // Saturating decrement: anything at or below the step lands on zero instead of wrapping.
    function automatic logic [7:0] decay_sat(input logic [7:0] lvl);
        logic [7:0] res;
        if (lvl > STEP) begin
            res = lvl - STEP;
        end else begin
            res = 8'd0;
        end
        return res;
    endfunction

    // (level * (dim+1)) >> 8; dim=255 is an exact pass-through.
    function automatic logic [7:0] dim_scale(input logic [7:0] lvl, input logic [8:0] d_p1);
        logic [15:0] prod;
        prod = {8'd0, lvl} * {7'd0, d_p1};
        return 8'(prod >> 8);
    endfunction

    // Free-running PWM counter and decay prescaler.
    always_comb begin
        tick_s        = (presc_r == PRESC_MAX);
        pwm_cnt_nxt_s = pwm_cnt_r + 8'd1;
        if (tick_s) begin
            presc_nxt_s = {PW{1'b0}};
        end else begin
            presc_nxt_s = presc_r + PW'(1);
        end
    end

    // Per-channel level priority (input beats tick), dim scaling and PWM compare.
    always_comb begin
        dim_p1_s      = {1'b0, dim} + 9'd1;
        led_out_nxt_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            level_nxt_s[i]   = level_r[i];
            eff_nxt_s[i]     = dim_scale(level_r[i], dim_p1_s);
            led_out_nxt_s[i] = (eff_r[i] > pwm_cnt_r);
            if (led_in[i]) begin
                level_nxt_s[i] = LEVEL_FULL;
            end else if (tick_s) begin
                level_nxt_s[i] = decay_sat(level_r[i]);
            end else begin
                level_nxt_s[i] = level_r[i];
            end
        end
    end

    // State registers; reset clears everything immediately, even mid-fade.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= 8'd0;
            presc_r   <= {PW{1'b0}};
            led_out_r <= {N_CH{1'b0}};
            for (int i = 0; i < N_CH; i++) begin
                level_r[i] <= 8'd0;
                eff_r[i]   <= 8'd0;
            end
        end else begin
            pwm_cnt_r <= pwm_cnt_nxt_s;
            presc_r   <= presc_nxt_s;
            led_out_r <= led_out_nxt_s;
            for (int i = 0; i < N_CH; i++) begin
                level_r[i] <= level_nxt_s[i];
                eff_r[i]   <= eff_nxt_s[i];
            end
        end
    end

    assign led_out = led_out_r;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: a reference model feeds a scoreboard queue every cycle,
// plus targeted checks on reset, duty cycles, dimming, tick collisions and the rotating trail.
`timescale 1ns/1ps
module tb_led_trail_pwm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] led_in;
    logic [7:0] dim;
    logic [3:0] led_out;
    logic [0:0] led_in2, led_out2, led_in3, led_out3;
    logic [7:0] dim2, dim3;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  m_pwm;
    logic [1:0]  m_presc;
    logic [7:0]  m_level [4];
    logic [7:0]  m_eff   [4];
    logic [3:0]  m_out;
    logic [67:0] exp_q [$];

    int         hi, other, first_hi, found, n, cur, prv;
    logic [7:0] prev_lvl;
    logic [7:0] seen [$];
    int         when [$];
    logic [7:0] fade_exp [4] = '{8'd191, 8'd127, 8'd63, 8'd0};
    int         duty_exp [4] = '{191, 127, 63, 0};
    logic [3:0] pat      [4] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
    int         pat_ch   [4] = '{0, 3, 2, 1};

    always #5 clk = ~clk;

    led_trail_pwm #(.N_CH(4), .DECAY_DIV(4), .DECAY_STEP(64)) dut (
        .clk(clk), .rst(rst), .led_in(led_in), .dim(dim), .led_out(led_out));

    led_trail_pwm #(.N_CH(1), .DECAY_DIV(256), .DECAY_STEP(64)) dut2 (
        .clk(clk), .rst(rst), .led_in(led_in2), .dim(dim2), .led_out(led_out2));

    led_trail_pwm #(.N_CH(1), .DECAY_DIV(4), .DECAY_STEP(63)) dut3 (
        .clk(clk), .rst(rst), .led_in(led_in3), .dim(dim3), .led_out(led_out3));

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pwm   = 8'd0;
        m_presc = 2'd0;
        m_out   = 4'd0;
        for (int i = 0; i < 4; i++) begin
            m_level[i] = 8'd0;
            m_eff[i]   = 8'd0;
        end
    endtask

    // One rising edge of the reference (DECAY_DIV=4, DECAY_STEP=64) using current inputs.
    task automatic model_edge();
        logic       tk;
        logic [7:0] nl [4];
        logic [7:0] ne [4];
        logic [3:0] no;
        tk = (m_presc == 2'd3);
        for (int i = 0; i < 4; i++) begin
            no[i] = (m_eff[i] > m_pwm);
            ne[i] = 8'((int'(m_level[i]) * (int'(dim) + 1)) / 256);
            if (led_in[i])
                nl[i] = 8'd255;
            else if (tk)
                nl[i] = (m_level[i] > 8'd64) ? m_level[i] - 8'd64 : 8'd0;
            else
                nl[i] = m_level[i];
        end
        for (int i = 0; i < 4; i++) begin
            m_level[i] = nl[i];
            m_eff[i]   = ne[i];
        end
        m_out   = no;
        m_pwm   = m_pwm + 8'd1;
        m_presc = m_presc + 2'd1;
    endtask

    function automatic logic [67:0] snap_model();
        return {m_out, m_eff[3], m_eff[2], m_eff[1], m_eff[0],
                m_level[3], m_level[2], m_level[1], m_level[0]};
    endfunction

    function automatic logic [67:0] snap_dut();
        return {led_out, dut.eff_r[3], dut.eff_r[2], dut.eff_r[1], dut.eff_r[0],
                dut.level_r[3], dut.level_r[2], dut.level_r[1], dut.level_r[0]};
    endfunction

    task automatic cyc();
        model_edge();
        exp_q.push_back(snap_model());
        @(posedge clk);
        #1;
        check("scoreboard", snap_dut(), exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; led_in = 4'b0000; dim = 8'd255;
        led_in2 = 1'b1; dim2 = 8'd255; led_in3 = 1'b1; dim3 = 8'd255;
        model_reset();
        #12;
        check("por_led_out", 68'(led_out), 68'd0);
        check("por_level0", 68'(dut.level_r[0]), 68'd0);
        rst = 1'b0;

        // Reset: hold 0001 for 600 cycles, then an asynchronous pulse
        led_in = 4'b0001;
        repeat (600) cyc();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_led_out", 68'(led_out), 68'd0);
        check("rst_pwm_cnt", 68'(dut.pwm_cnt_r), 68'd0);
        check("rst_level0", 68'(dut.level_r[0]), 68'd0);
        check("rst_eff0", 68'(dut.eff_r[0]), 68'd0);
        check("rst_led_out2", 68'(led_out2), 68'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        first_hi = 0;
        for (int e = 1; e <= 10 && first_hi == 0; e++) begin
            cyc();
            if (led_out[0]) first_hi = e;
        end
        check("first_high_edge", 68'(first_hi), 68'd3);

        // Full on
        repeat (300) cyc();
        hi = 0; other = 0;
        repeat (256) begin
            cyc();
            hi    += int'(led_out[0]);
            other += int'(led_out[3:1] != 3'd0);
        end
        check("full_duty", 68'(hi), 68'd255);
        check("full_others", 68'(other), 68'd0);

        // Fade on the fast-decay instance
        led_in = 4'b0000;
        prev_lvl = 8'd255;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (dut.level_r[0] != prev_lvl) begin
                prev_lvl = dut.level_r[0];
                seen.push_back(prev_lvl);
                when.push_back(c);
            end
        end
        check("fade_nsteps", 68'(seen.size()), 68'd4);
        for (int k = 0; k < 4; k++)
            if (k < seen.size()) check("fade_level", 68'(seen[k]), 68'(fade_exp[k]));
        for (int k = 1; k < 4; k++)
            if (k < when.size()) check("fade_spacing", 68'(when[k] - when[k-1]), 68'd4);
        check("fade_hold", 68'(dut.level_r[0]), 68'd0);

        // Fade duty on the DECAY_DIV=256 instance, whose ticks line up with PWM periods
        led_in2 = 1'b0;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            cyc();
            if (dut2.level_r[0] != 8'd255) found = 1;
        end
        check("slow_tick_seen", 68'(found), 68'd1);
        cyc();
        for (int w = 0; w < 4; w++) begin
            hi = 0;
            repeat (256) begin
                cyc();
                hi += int'(led_out2[0]);
            end
            check("fade_duty", 68'(hi), 68'(duty_exp[w]));
        end

        // Dim scaling
        led_in = 4'b0010; dim = 8'd127;
        repeat (4) cyc();
        check("dim127_eff", 68'(dut.eff_r[1]), 68'd127);
        hi = 0;
        repeat (256) begin cyc(); hi += int'(led_out[1]); end
        check("dim127_duty", 68'(hi), 68'd127);
        dim = 8'd0;
        repeat (3) cyc();
        check("dim0_eff", 68'(dut.eff_r[1]), 68'd0);
        hi = 0;
        repeat (256) begin cyc(); hi += int'(led_out[1]); end
        check("dim0_duty", 68'(hi), 68'd0);
        repeat (100) cyc();
        dim = 8'd255;
        cyc();
        check("dim_step_eff", 68'(dut.eff_r[1]), 68'd255);

        // Collision: input rises on the very edge that would decay 63 to 0
        led_in = 4'b0100;
        repeat (2) cyc();
        led_in = 4'b0000;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (m_presc == 2'd3 && m_level[2] == 8'd63) found = 1;
            else cyc();
        end
        check("collide_setup", 68'(found), 68'd1);
        led_in = 4'b0100;
        cyc();
        check("collide_level", 68'(dut.level_r[2]), 68'd255);

        // Saturation: 255,192,129,66,3 then 0 (a wrap would give 196)
        led_in3 = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            cyc();
            if (dut3.level_r[0] == 8'd3) found = 1;
        end
        check("sat_reach3", 68'(found), 68'd1);
        n = 0;
        while (dut3.level_r[0] == 8'd3 && n < 6) begin cyc(); n++; end
        check("sat_no_wrap", 68'(dut3.level_r[0]), 68'd0);

        // Trail: every 8-cycle segment spans exactly two ticks, so the previous channel sits at 127
        for (int r = 0; r < 8; r++) begin
            led_in = pat[r % 4];
            repeat (8) cyc();
            cur = pat_ch[r % 4];
            prv = pat_ch[(r + 3) % 4];
            check("trail_cur", 68'(dut.level_r[cur]), 68'd255);
            if (r > 0) check("trail_prev", 68'(dut.level_r[prv]), 68'd127);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
